uart_rx: RTL and testbench

//  8N1 UART receiver directly downstream of the top-level glue's rx pin buffer.

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte delivery channel of the UART receiver: one-deep holding register with valid/ready.
interface uart_rx_if;
   // A byte moves when valid && ready at posedge clk; data is stable while valid is high
   // and ready is ignored while valid is low.
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop rx synchroniser, mid-bit sampling FSM, one-deep output
// holding register with framing-error and overrun pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 579,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   uart_rx_if.master  bus,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy,
   output logic [2:0] state_dbg
);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t           state, state_nx;
   logic             rx_meta, rx_s;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [2:0]       bit_idx, bit_idx_nx;
   logic [7:0]       shreg, shreg_nx;
   logic             byte_done, byte_done_nx;
   logic             frame_err_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      bit_idx_nx   = bit_idx;
      shreg_nx     = shreg;
      byte_done_nx = 1'b0;
      frame_err_nx = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (!rx_s) state_nx = START;
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_nx     = '0;
               bit_idx_nx = '0;
               state_nx   = rx_s ? IDLE : DATA;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nx     = '0;
               shreg_nx   = {rx_s, shreg[7:1]};
               bit_idx_nx = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_nx = STOP;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nx = '0;
               if (rx_s) begin
                  byte_done_nx = 1'b1;
                  state_nx     = IDLE;
               end else begin
                  frame_err_nx = 1'b1;
                  state_nx     = BRK;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         BRK: begin
            // A held-low line must go high before a new start bit is accepted.
            cnt_nx = '0;
            if (rx_s) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         bus.data  <= '0;
         bus.valid <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         bit_idx   <= bit_idx_nx;
         shreg     <= shreg_nx;
         byte_done <= byte_done_nx;
         frame_err <= frame_err_nx;
         overrun   <= 1'b0;
         // shreg is untouched in IDLE/START, so it still holds the byte one cycle later.
         if (byte_done) begin
            if (!bus.valid || bus.ready) begin
               bus.data  <= shreg;
               bus.valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (bus.valid && bus.ready) begin
            bus.valid <= 1'b0;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic against a
// frame-level timing model of the receiver's outputs.
module tb_uart_rx;
  localparam int C = 16;
  localparam int H = C / 2;
  localparam int NEVER = 1 << 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       frame_err, overrun, busy;
  logic [2:0] state_dbg;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .bus       (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit rand_mode = 1'b0;
  bit ready_dir = 1'b0;

  // One entry per frame put on the wire; edges are posedge numbers (cyc after that edge).
  typedef struct {
    int         busy_from;
    int         busy_to;
    int         pop_edge;
    int         dlv_edge;
    int         ferr_edge;
    logic [7:0] b;
  } frame_t;
  frame_t fq[$];

  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_busy = 1'b0;

  // monitor counters (DUT-observed, compared against hand-computed literals)
  int         n_vrise = 0, n_ferr = 0, n_ovr = 0, rise_edge = 0, hi_len = 0;
  logic [7:0] rise_data = 8'h00;
  logic       prev_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // reference model: holding register behaviour driven by the frame timeline
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_ferr <= 1'b0;
    m_ovr  <= 1'b0;
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_busy  <= 1'b0;
      fq.delete();
    end else begin
      if (fq.size() > 0 && fq[0].dlv_edge == cyc + 1) begin
        if (!m_valid || bus.ready) begin
          m_valid <= 1'b1;
          m_data  <= fq[0].b;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (m_valid && bus.ready) begin
        m_valid <= 1'b0;
      end
      if (fq.size() > 0 && fq[0].ferr_edge == cyc + 1) m_ferr <= 1'b1;
      m_busy <= (fq.size() > 0) && (cyc + 1 >= fq[0].busy_from) && (cyc + 1 < fq[0].busy_to);
      if (fq.size() > 0 && fq[0].pop_edge == cyc + 1) void'(fq.pop_front());
    end
  end

  // compare process
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("valid", 32'(bus.valid), 32'(m_valid));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("busy", 32'(busy), 32'(m_busy));
      if (m_valid) check("data", 32'(bus.data), 32'(m_data));
    end
  end

  // monitor
  initial forever begin
    @(negedge clk);
    if (bus.valid && !prev_v) begin
      n_vrise++;
      rise_edge = cyc;
      rise_data = bus.data;
      hi_len = 0;
    end
    if (bus.valid) hi_len++;
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    prev_v = bus.valid;
  end

  // ready driver
  initial begin
    bus.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_dir;
    end
  end

  // Drives one frame starting right now (caller sits just after a posedge). A low stop
  // bit keeps the line low for 'hold' more bit-free cycles, then releases it for one cycle.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int hold, output int e);
    frame_t f;
    int stop_edge, r;
    e = cyc;
    stop_edge = e + 3 + H + 9 * C;
    f.b = b;
    f.busy_from = e + 3;
    if (stop) begin
      f.busy_to = stop_edge;
      f.dlv_edge = stop_edge + 1;
      f.pop_edge = stop_edge + 1;
      f.ferr_edge = -1;
    end else begin
      r = e + 10 * C + hold;
      f.busy_to = r + 3;
      f.pop_edge = r + 3;
      f.dlv_edge = -1;
      f.ferr_edge = stop_edge;
    end
    fq.push_back(f);
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(C);
      rx = b[i];
    end
    step(C);
    rx = stop;
    step(C);
    if (!stop) begin
      step(hold);
      rx = 1'b1;
      step(1);
    end
    rx = 1'b1;
  endtask

  task automatic glitch(input int len);
    frame_t f;
    f.b = 8'h00;
    f.busy_from = cyc + 3;
    f.busy_to = cyc + 3 + H;
    f.pop_edge = cyc + 3 + H;
    f.dlv_edge = -1;
    f.ferr_edge = -1;
    fq.push_back(f);
    rx = 1'b0;
    step(len);
    rx = 1'b1;
    step(H + 4);
  endtask

  int e1, e2, sv_rise, sv_ferr, sv_ovr;
  logic [7:0] rb;
  bit bad;
  int hold;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    step(4);

    // 1: 0xA5 with ready high
    ready_dir = 1'b1;
    step(1);
    sv_rise = n_vrise;
    send_frame(8'hA5, 1'b1, 0, e1);
    step(6);
    check("t1_rises", 32'(n_vrise - sv_rise), 32'd1);
    check("t1_latency", 32'(rise_edge - e1), 32'd156);
    check("t1_data", 32'(rise_data), 32'hA5);
    check("t1_pulse_len", 32'(hi_len), 32'd1);

    // 2: 0x3C held for 50 cycles, then drained
    ready_dir = 1'b0;
    step(1);
    send_frame(8'h3C, 1'b1, 0, e1);
    step(50);
    check("t2_held_valid", 32'(bus.valid), 32'd1);
    check("t2_held_data", 32'(bus.data), 32'h3C);
    ready_dir = 1'b1;
    step(3);
    check("t2_drained", 32'(bus.valid), 32'd0);

    // 5: short low glitch
    sv_rise = n_vrise; sv_ferr = n_ferr; sv_ovr = n_ovr;
    glitch(5);
    check("t5_no_valid", 32'(n_vrise - sv_rise), 32'd0);
    check("t5_no_flags", 32'((n_ferr - sv_ferr) + (n_ovr - sv_ovr)), 32'd0);

    // 4: 0x55 with low stop bit, line held low
    sv_ferr = n_ferr; sv_rise = n_vrise;
    send_frame(8'h55, 1'b0, 40, e1);
    step(5);
    check("t4_ferr_count", 32'(n_ferr - sv_ferr), 32'd1);
    check("t4_no_valid", 32'(n_vrise - sv_rise), 32'd0);

    // 3: 0x11 then 0x22 back-to-back, nobody draining
    ready_dir = 1'b0;
    step(1);
    sv_ovr = n_ovr;
    send_frame(8'h11, 1'b1, 0, e1);
    send_frame(8'h22, 1'b1, 0, e2);
    step(5);
    check("t3_b2b_spacing", 32'(e2 - e1), 32'd160);
    check("t3_ovr_count", 32'(n_ovr - sv_ovr), 32'd1);
    check("t3_data_kept", 32'(bus.data), 32'h11);
    check("t3_valid_kept", 32'(bus.valid), 32'd1);

    // 6: reset in the middle of 0xFF, then 0x81
    begin
      frame_t f;
      f.b = 8'hFF; f.busy_from = cyc + 3; f.busy_to = NEVER;
      f.pop_edge = NEVER; f.dlv_edge = -1; f.ferr_edge = -1;
      fq.push_back(f);
    end
    rx = 1'b0;
    step(C);
    rx = 1'b1;
    step(3 * C);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(bus.valid), 32'd0);
    step(C);
    ready_dir = 1'b1;
    sv_rise = n_vrise;
    send_frame(8'h81, 1'b1, 0, e1);
    step(4);
    check("t6_rx_after", 32'(n_vrise - sv_rise), 32'd1);
    check("t6_data", 32'(rise_data), 32'h81);

    // randomized traffic
    rand_mode = 1'b1;
    for (int k = 0; k < 24; k++) begin
      rb = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      hold = $urandom_range(0, 30);
      send_frame(rb, !bad, hold, e1);
      step($urandom_range(0, 20));
    end
    rand_mode = 1'b0;
    ready_dir = 1'b1;
    step(2 * C);
    check("end_queue_empty", 32'(fq.size()), 32'd0);
    check("end_valid", 32'(bus.valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
